// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with a direct-mapped instruction cache.
//
// Holds the fetch PC and looks it up in the cache. A hit presents `instr` and
// `ihit` to decode in the same cycle. A miss refills one line, one word per
// beat, over a req/ack handshake. Redirects from the M stage and `stall` from
// the hazard logic steer the PC.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   stall             hold the PC (never blocks a refill or masks ihit)
//   redirect,
//   redirect_pc       taken branch/jump target (low two bits dropped)
//   pc_f              current fetch PC
//   instr, ihit       fetched word; NOP when ihit=0
//   mem_req, mem_addr refill beat request and word address
//   mem_ack,
//   mem_rdata         beat accepted, with its data
//   hit_count,
//   miss_count        saturating statistics (ICACHE_STATS_EN only)
//
// Optional feature macro: ICACHE_STATS_EN adds the hit/miss counters.

module fetch_unit #(
    parameter int          LINES      = 16,
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_f,
    output logic [31:0] instr,
    output logic        ihit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - OFF_W - IDX_W - 2;
    localparam logic [31:0]      NOP       = 32'h0000_0013;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        miss_addr_q, miss_addr_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic [LINES-1:0]   valid_q, valid_d;

    // Tag/data arrays and the refill line buffer carry no reset.
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES][LINE_WORDS];
    logic [31:0]        buf_q  [LINE_WORDS];

    logic               beat_we;
    logic               line_we;

    logic [OFF_W-1:0]   pc_off;
    logic [IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic [IDX_W-1:0]   miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic               lookup_hit;

    assign pc_off   = pc_q[OFF_W+1:2];
    assign pc_idx   = pc_q[OFF_W+IDX_W+1:OFF_W+2];
    assign pc_tag   = pc_q[31:OFF_W+IDX_W+2];
    assign miss_idx = miss_addr_q[OFF_W+IDX_W+1:OFF_W+2];
    assign miss_tag = miss_addr_q[31:OFF_W+IDX_W+2];

    assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign pc_f       = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        miss_addr_d = miss_addr_q;
        beat_d      = beat_q;
        valid_d     = valid_q;
        ihit        = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = 32'h0;
        beat_we     = 1'b0;
        line_we     = 1'b0;

        case (state_q)
            IDLE: begin
                ihit = lookup_hit;
                // A redirect in the miss cycle restarts lookup at the target
                // instead of fetching a line nobody wants.
                if (!lookup_hit && !redirect) begin
                    state_d     = REFILL;
                    miss_addr_d = {pc_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                    beat_d      = '0;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = miss_addr_q + 32'({beat_q, 2'b00});
                if (mem_ack) begin
                    beat_we = 1'b1;
                    beat_d  = beat_q + OFF_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        line_we           = 1'b1;
                        valid_d[miss_idx] = 1'b1;
                        state_d           = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirects never abort a refill; the target is looked up once the
        // refill returns to IDLE.
        if (redirect)
            pc_d = redirect_pc & ~32'h3;
        else if (ihit && !stall)
            pc_d = pc_q + 32'd4;
    end

    assign instr = ihit ? data_q[pc_idx][pc_off] : NOP;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            miss_addr_q <= 32'h0;
            beat_q      <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            miss_addr_q <= miss_addr_d;
            beat_q      <= beat_d;
            valid_q     <= valid_d;
        end
    end

    // The last beat goes straight from mem_rdata into the array so the line
    // is usable the cycle after the final ack.
    always_ff @(posedge clk) begin
        if (reset && beat_we)
            buf_q[beat_q] <= mem_rdata;
        if (reset && line_we) begin
            tag_q[miss_idx] <= miss_tag;
            for (int w = 0; w < LINE_WORDS; w++)
                data_q[miss_idx][w] <= (w == LINE_WORDS - 1) ? mem_rdata : buf_q[w];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == IDLE && ihit && !stall && hit_cnt_q != 32'hFFFF_FFFF)
            hit_cnt_d = hit_cnt_q + 32'd1;
        if (state_q == IDLE && state_d == REFILL && miss_cnt_q != 32'hFFFF_FFFF)
            miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Memory returns data equal to the address.
// Outputs are sampled 1 time unit after each rising edge.

module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_f;
    logic [31:0] instr;
    logic        ihit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .pc_f       (pc_f),
        .instr      (instr),
        .ihit       (ihit),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Memory model: every word holds its own address.
    assign mem_rdata = mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] pc, input logic hit,
                             input logic [31:0] ins);
        chk({tag, ".pc"}, pc_f, pc);
        chk({tag, ".ihit"}, 32'(ihit), 32'(hit));
        chk({tag, ".instr"}, instr, ins);
    endtask

    task automatic chk_mem(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, 32'(mem_req), 32'(req));
        chk({tag, ".addr"}, mem_addr, addr);
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_ack     = 1'b1;

        // Reset held two cycles
        tick();
        chk_fetch("rst", 32'h1000, 1'b0, NOP);
        chk_mem("rst", 1'b0, 32'h0);
`ifdef ICACHE_STATS_EN
        chk("rst.hits", hit_count, 32'd0);
        chk("rst.miss", miss_count, 32'd0);
`endif
        tick();
        reset = 1'b1;

        // Cold miss at 0x1000, zero-wait refill
        tick(); chk_mem("cold.b0", 1'b1, 32'h1000); chk("cold.b0.ihit", 32'(ihit), 32'd0);
        tick(); chk_mem("cold.b1", 1'b1, 32'h1004);
        tick(); chk_mem("cold.b2", 1'b1, 32'h1008);
        tick(); chk_mem("cold.b3", 1'b1, 32'h100C);
        tick(); chk_fetch("cold.hit0", 32'h1000, 1'b1, 32'h1000); chk_mem("cold.done", 1'b0, 32'h0);
        tick(); chk_fetch("cold.hit1", 32'h1004, 1'b1, 32'h1004);

        // Stall for 3 cycles: PC holds, ihit stays up
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_fetch("stall", 32'h1004, 1'b1, 32'h1004);
        end

        // Redirect with stall in the same cycle: redirect wins
        redirect = 1'b1; redirect_pc = 32'h1000;
        tick(); chk_fetch("redir_stall", 32'h1000, 1'b1, 32'h1000);
        redirect = 1'b0; stall = 1'b0;
        tick(); chk_fetch("seq1", 32'h1004, 1'b1, 32'h1004);
        tick(); chk_fetch("seq2", 32'h1008, 1'b1, 32'h1008);
        tick(); chk_fetch("seq3", 32'h100C, 1'b1, 32'h100C);
        tick(); chk_fetch("seq4", 32'h1010, 1'b0, NOP);
`ifdef ICACHE_STATS_EN
        // Counted hits: 0x1000, then 0x1000/0x1004/0x1008/0x100C after the stall
        chk("seq4.hits", hit_count, 32'd5);
        chk("seq4.miss", miss_count, 32'd1);
`endif

        // Refill of 0x1010 with a redirect to 0x2002 during beat 1
        tick(); chk_mem("r1010.b0", 1'b1, 32'h1010);
        tick(); chk_mem("r1010.b1", 1'b1, 32'h1014);
        redirect = 1'b1; redirect_pc = 32'h2002;
        tick(); chk_mem("r1010.b2", 1'b1, 32'h1018); chk_fetch("r1010.pc", 32'h2000, 1'b0, NOP);
        redirect = 1'b0;
        tick(); chk_mem("r1010.b3", 1'b1, 32'h101C);
        tick(); chk_mem("r1010.done", 1'b0, 32'h0); chk_fetch("at2000", 32'h2000, 1'b0, NOP);

        // Redirect in an IDLE miss cycle: no refill; 0x1010 line was filled
        redirect = 1'b1; redirect_pc = 32'h1010;
        tick(); chk_fetch("hit1010", 32'h1010, 1'b1, 32'h1010); chk_mem("norefill", 1'b0, 32'h0);
        redirect_pc = 32'h2000;
        tick(); chk_fetch("back2000", 32'h2000, 1'b0, NOP); chk_mem("back2000", 1'b0, 32'h0);
        redirect = 1'b0;
        tick(); chk_mem("r2000.b0", 1'b1, 32'h2000);
`ifdef ICACHE_STATS_EN
        chk("r2000.hits", hit_count, 32'd6);
        chk("r2000.miss", miss_count, 32'd3);
`endif
        tick(); chk_mem("r2000.b1", 1'b1, 32'h2004);
        tick(); chk_mem("r2000.b2", 1'b1, 32'h2008);

        // Reset during beat 2; acks keep coming
        reset = 1'b0;
        tick(); chk_mem("midrst", 1'b0, 32'h0); chk_fetch("midrst", 32'h1000, 1'b0, NOP);
`ifdef ICACHE_STATS_EN
        chk("midrst.hits", hit_count, 32'd0);
        chk("midrst.miss", miss_count, 32'd0);
`endif
        reset = 1'b1;
        // 0x1000 misses again; the ack in the IDLE cycle did not advance anything
        tick(); chk_mem("re1000.b0", 1'b1, 32'h1000);
        // One wait state: request holds
        mem_ack = 1'b0;
        tick(); chk_mem("re1000.wait", 1'b1, 32'h1000);
        mem_ack = 1'b1;
        tick(); chk_mem("re1000.b1", 1'b1, 32'h1004);
        tick(); chk_mem("re1000.b2", 1'b1, 32'h1008);
        tick(); chk_mem("re1000.b3", 1'b1, 32'h100C);
        tick(); chk_fetch("re1000.hit", 32'h1000, 1'b1, 32'h1000);
`ifdef ICACHE_STATS_EN
        chk("re1000.miss", miss_count, 32'd1);
`endif

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); chk_fetch("top", 32'hFFFF_FFFC, 1'b0, NOP);
        redirect = 1'b0;
        tick(); chk_mem("rtop.b0", 1'b1, 32'hFFFF_FFF0);
        tick(); chk_mem("rtop.b1", 1'b1, 32'hFFFF_FFF4);
        tick(); chk_mem("rtop.b2", 1'b1, 32'hFFFF_FFF8);
        tick(); chk_mem("rtop.b3", 1'b1, 32'hFFFF_FFFC);
        tick(); chk_fetch("rtop.hit", 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
        tick(); chk_fetch("wrap", 32'h0000_0000, 1'b0, NOP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined core, directly upstream of the main decoder: it holds the fetch PC, looks it up in a direct-mapped instruction cache, and presents `instr` plus `ihit` to decode. On a miss it refills one line from instruction memory over a req/ack handshake. Branch/jump redirects from the M stage and back-pressure from the data side (stall) are applied here.

## Interface
Parameters:
- `LINES`, 16: cache lines; power of two.
- `LINE_WORDS`, 4: 32-bit words per line; power of two.
- `RESET_PC`, 32'h0000_1000: PC loaded at reset; word aligned.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hold PC; driven by the hazard/data-miss logic.
- `redirect`  in  1  taken branch/jump from M stage.
- `redirect_pc`  in  32  redirect target.
- `pc_f`  out  32  current fetch PC.
- `instr`  out  32  fetched instruction; NOP (32'h0000_0013) when `ihit`=0.
- `ihit`  out  1  `instr` valid this cycle.
- `mem_req`  out  1  refill beat request.
- `mem_addr`  out  32  refill beat word address.
- `mem_ack`  in  1  beat accepted; `mem_rdata` valid.
- `mem_rdata`  in  32  refill data.
- `hit_count`, `miss_count`  out  32 each  present only with ICACHE_STATS_EN.

## Operation
- Address split: offset = `pc_f[log2(LINE_WORDS)+1:2]`, index = next log2(LINES) bits, tag = remaining upper bits. `pc_f[1:0]` always 0.
- Storage: valid bit, tag, and LINE_WORDS data words per line. All valid bits cleared by reset; data/tag not reset.
- FSM states:
  - IDLE: combinational lookup of `pc_f`. `ihit` = valid & tag match. On miss (and no redirect): latch line base of `pc_f` into `miss_addr`, clear beat counter, go to REFILL.
  - REFILL: `mem_req`=1, `mem_addr` = `miss_addr` + 4*beat. Each `mem_ack` writes `mem_rdata` into the line buffer and increments the beat counter. On the ack of beat LINE_WORDS-1: write the line, set valid and tag, go to IDLE. `ihit`=0 throughout.
- PC update, in priority order:
  1. reset: `RESET_PC`.
  2. redirect: `redirect_pc` & ~3, in any state.
  3. `ihit` & ~`stall`: `pc_f`+4, wrapping modulo 2^32.
  4. Otherwise hold.
- Redirect during REFILL does not abort the refill. The line for `miss_addr` is still filled; the new PC is looked up on return to IDLE.
- Redirect while in IDLE with a miss: no refill starts that cycle; the lookup restarts at the new PC.
- `stall` never blocks a refill, and never masks `ihit`.
- `mem_ack` is ignored outside REFILL.
- Reset mid-refill: returns to IDLE, `mem_req`=0 from the next cycle, valid bits cleared.

## Timing
- Reset values: `pc_f`=`RESET_PC`, `ihit`=0, `instr`=NOP, `mem_req`=0, `mem_addr`=0, counters=0.
- Hit latency: 0 cycles, combinational from the `pc_f` register. One instruction per cycle on consecutive hits.
- Miss sequence, with the miss seen in cycle t:
  - `mem_req` rises in t+1.
  - Final ack in cycle a: line written at the end of cycle a; `ihit`=1 in a+1.
  - Zero-wait memory (ack every cycle): `ihit` returns at t+1+LINE_WORDS.
- Handshake: `mem_req`/`mem_addr` stay stable until `mem_ack`. A beat completes in a cycle where `mem_req` & `mem_ack` are both high. Back-to-back beats are allowed.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Ports `hit_count` and `miss_count` are present.
  - `hit_count` increments in each IDLE cycle with `ihit` & ~`stall`.
  - `miss_count` increments on each IDLE→REFILL transition.
  - Both counters saturate at 2^32-1 and clear on reset.
- Not defined: both ports and all counter logic are absent.

## Test plan
- Cold start: reset low 2 cycles, then high; memory acks every cycle with data = address.
  - `mem_req` asserts the cycle after reset is released, with `mem_addr` = 0x1000, 0x1004, 0x1008, 0x100C.
  - `ihit`=1 with `instr`=0x1000, then 0x1004 the following cycle.
- Hits with stall: run the warm line with `stall`=1 for 3 cycles.
  - `pc_f` holds at 0x1004; `ihit` stays 1; `instr` is stable.
- Redirect mid-refill: `redirect`=1 with `redirect_pc`=0x2002 during beat 1 of the 0x1010 refill.
  - All 4 beats of 0x1010 complete.
  - `pc_f`=0x2000, and the next refill is at 0x2000.
- Redirect with stall in the same cycle: `redirect_pc`=0x1000 wins; `pc_f`=0x1000 next cycle and hits.
- Reset mid-refill: reset low during beat 2.
  - `mem_req`=0 next cycle and late acks are ignored.
  - After release, 0x1000 misses again because valid bits were cleared.
- With `ICACHE_STATS_EN`: cold start followed by 4 hits → `miss_count`=1, `hit_count`=4.
